// File: rtl/avalon_mem_responder.sv
// Data-bus responder: address decode, fixed wait-state insertion and a local
// DEPTH x 16 RAM behind the avalon_bus data handshake.
module avalon_mem_responder #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReadData,
  input  logic        WriteData,
  input  logic [15:0] DataAddr,
  input  logic [15:0] DataOut,
  output logic [15:0] DataIn,
  output logic        Waitreq,
  output logic        ErrFlag
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam logic [3:0] WAIT_C  = 4'(WAIT_CYCLES);
  localparam logic [3:0] WAIT_M1 = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] data_in_q, data_in_d;
  logic        err_q, err_d;
  logic [15:0] mem [DEPTH];

  logic                 req;
  logic                 hit;
  logic                 both;
  logic [ADDR_BITS-1:0] idx;
  logic                 accept;
  logic                 abort;
  logic                 rd_load;
  logic                 ram_we;

  assign req  = ReadData | WriteData;
  assign both = ReadData & WriteData;
  assign hit  = (DataAddr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
  assign idx  = DataAddr[ADDR_BITS-1:0];

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_in_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_in_q <= data_in_d;
      err_q     <= err_d;
    end
  end

  // Next state: state mirrors the wait counter phase, DONE marks the accept cycle
  always_comb begin
    cnt_d = cnt_q;
    if (!req || state_q == ST_DONE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
    if (cnt_d == WAIT_C) begin
      state_d = ST_DONE;
    end else if (cnt_d != '0) begin
      state_d = ST_WAIT;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Outputs and handshake qualifiers
  always_comb begin
    Waitreq = Reset | (req & (state_q != ST_DONE));
    accept  = req & (state_q == ST_DONE);
    abort   = ~req & (state_q != ST_IDLE);
    rd_load = req & ReadData & (cnt_q == WAIT_M1);
    ram_we  = accept & WriteData & ~ReadData & hit & ~Reset;
  end

  // Read data is captured one cycle early so it is registered through the accept cycle
  always_comb begin
    data_in_d = data_in_q;
    if (rd_load) begin
      data_in_d = hit ? mem[idx] : '0;
    end
    err_d = err_q | abort | (accept & (~hit | both));
  end

  always_ff @(posedge Clock) begin
    if (ram_we) begin
      mem[idx] <= DataOut;
    end
  end

  assign DataIn  = data_in_q;
  assign ErrFlag = err_q;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed and randomized checks of avalon_mem_responder against a transaction-level
// model (word array, sticky error bit, last read word).
module tb_avalon_mem_responder;

  localparam int unsigned W = 2;

  logic        Clock;
  logic        Reset;
  logic        ReadData;
  logic        WriteData;
  logic [15:0] DataAddr;
  logic [15:0] DataOut;
  logic [15:0] DataIn;
  logic        Waitreq;
  logic        ErrFlag;

  int unsigned n_vec;
  int unsigned n_bad;

  logic [15:0] model_mem [1024];
  bit          written [1024];
  logic        m_err;
  logic [15:0] m_din;

  avalon_mem_responder #(
    .ADDR_BITS  (10),
    .BASE_ADDR  (16'h0000),
    .WAIT_CYCLES(W)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .ReadData (ReadData),
    .WriteData(WriteData),
    .DataAddr (DataAddr),
    .DataOut  (DataOut),
    .DataIn   (DataIn),
    .Waitreq  (Waitreq),
    .ErrFlag  (ErrFlag)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset(input int unsigned n);
    Reset = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge Clock);
      chk("waitreq_in_reset", {15'b0, Waitreq}, 16'd1);
      next_cycle();
    end
    Reset = 1'b0;
    m_err = 1'b0;
    m_din = 16'h0000;
  endtask

  task automatic idle(input int unsigned n);
    ReadData  = 1'b0;
    WriteData = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge Clock);
      chk("idle_waitreq", {15'b0, Waitreq}, 16'd0);
      chk("idle_errflag", {15'b0, ErrFlag}, {15'b0, m_err});
      chk("idle_datain", DataIn, m_din);
      next_cycle();
    end
  endtask

  // One complete transfer; strobes are left asserted so calls can run back to back.
  task automatic xfer(input logic rd, input logic wr, input logic [15:0] addr,
                      input logic [15:0] dout);
    logic        hit;
    logic [15:0] exp_din;
    hit = (addr[15:10] == 6'd0);
    ReadData  = rd;
    WriteData = wr;
    DataAddr  = addr;
    DataOut   = dout;
    if (rd) exp_din = hit ? model_mem[addr[9:0]] : 16'h0000;
    else    exp_din = m_din;
    for (int unsigned c = 0; c <= W; c++) begin
      @(negedge Clock);
      chk("xfer_waitreq", {15'b0, Waitreq}, (c < W) ? 16'd1 : 16'd0);
      if (c == W) begin
        chk("accept_datain", DataIn, exp_din);
        chk("accept_errflag", {15'b0, ErrFlag}, {15'b0, m_err});
      end
      next_cycle();
    end
    m_din = exp_din;
    if (rd) begin
      if (!hit || wr) m_err = 1'b1;
    end else if (hit) begin
      model_mem[addr[9:0]] = dout;
      written[addr[9:0]]   = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  // Raise strobes for k cycles (k < W) and then withdraw them while still waited.
  task automatic abort_xfer(input logic rd, input logic wr, input logic [15:0] addr,
                            input logic [15:0] dout, input int unsigned k);
    ReadData  = rd;
    WriteData = wr;
    DataAddr  = addr;
    DataOut   = dout;
    for (int unsigned c = 0; c < k; c++) begin
      @(negedge Clock);
      chk("abort_waitreq", {15'b0, Waitreq}, 16'd1);
      next_cycle();
    end
    ReadData  = 1'b0;
    WriteData = 1'b0;
    @(negedge Clock);
    chk("abort_drop_waitreq", {15'b0, Waitreq}, 16'd0);
    next_cycle();
    m_err = 1'b1;
  endtask

  initial begin
    int unsigned kind;
    logic [15:0] a;
    logic [15:0] d;
    logic        r;
    n_vec     = 0;
    n_bad     = 0;
    m_err     = 1'b0;
    m_din     = 16'h0000;
    Reset     = 1'b1;
    ReadData  = 1'b0;
    WriteData = 1'b0;
    DataAddr  = 16'h0000;
    DataOut   = 16'h0000;
    next_cycle();

    // Reset and idle state
    do_reset(2);
    idle(2);

    // Single write then read
    xfer(1'b0, 1'b1, 16'h0005, 16'hBEEF);
    idle(1);
    xfer(1'b1, 1'b0, 16'h0005, 16'h0000);
    idle(1);

    // Back-to-back writes with strobe held, then back-to-back reads
    xfer(1'b0, 1'b1, 16'h0010, 16'h0001);
    xfer(1'b0, 1'b1, 16'h0011, 16'h0002);
    xfer(1'b0, 1'b1, 16'h0012, 16'h0003);
    xfer(1'b1, 1'b0, 16'h0010, 16'h0000);
    xfer(1'b1, 1'b0, 16'h0011, 16'h0000);
    xfer(1'b1, 1'b0, 16'h0012, 16'h0000);
    idle(1);

    // Out-of-region read
    xfer(1'b1, 1'b0, 16'h0400, 16'h0000);
    idle(1);

    // Aborted write keeps old contents; reset clears the sticky flag
    do_reset(1);
    xfer(1'b0, 1'b1, 16'h0020, 16'h5555);
    idle(1);
    abort_xfer(1'b0, 1'b1, 16'h0020, 16'h1234, 1);
    idle(1);
    xfer(1'b1, 1'b0, 16'h0020, 16'h0000);
    idle(1);
    do_reset(1);
    idle(1);

    // Both strobes act as a read; RAM is untouched
    xfer(1'b1, 1'b1, 16'h0005, 16'hAAAA);
    idle(1);
    xfer(1'b1, 1'b0, 16'h0005, 16'h0000);
    idle(1);

    // Reset in the middle of a wait, then a full-timing transfer
    ReadData = 1'b1;
    DataAddr = 16'h0005;
    @(negedge Clock);
    chk("prereset_waitreq", {15'b0, Waitreq}, 16'd1);
    next_cycle();
    do_reset(1);
    xfer(1'b1, 1'b0, 16'h0005, 16'h0000);
    idle(1);

    // Randomized traffic
    for (int unsigned i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 5);
      a    = 16'($urandom_range(0, 63));
      d    = 16'($urandom);
      r    = 1'($urandom);
      case (kind)
        0, 1: xfer(1'b0, 1'b1, a, d);
        2: begin
          if (!written[a[9:0]]) xfer(1'b0, 1'b1, a, d);
          xfer(1'b1, 1'b0, a, 16'h0000);
        end
        3: xfer(r, ~r, 16'($urandom_range(16'h0400, 16'hFFFF)), d);
        4: begin
          if (!written[a[9:0]]) xfer(1'b0, 1'b1, a, d);
          xfer(1'b1, 1'b1, a, ~d);
        end
        default: abort_xfer(r, ~r, a, d, W - 1);
      endcase
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
